// File: rtl/shot_tracker.sv
// Sequential wrapper around the combinational shot scorer: debounced key press,
// shot latch, one-cycle result sampling and game-state bookkeeping.
module shot_tracker #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned BIG_BOMBS          = 2,
    parameter int unsigned TOTAL_SHIP_SQUARES = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       score_n,
    input  logic [3:0] sw_x,
    input  logic [3:0] sw_y,
    input  logic       sw_big,
    input  logic       something_wrong,
    input  logic       is_hit,
    input  logic       is_near_miss,
    input  logic       is_miss,
    input  logic [4:0] biggest_ship,
    output logic [3:0] shot_x,
    output logic [3:0] shot_y,
    output logic       shot_big,
    output logic       score_strobe,
    output logic       hit_led,
    output logic       near_miss_led,
    output logic       miss_led,
    output logic [4:0] ship_hit_leds,
    output logic [3:0] hits_ones,
    output logic [3:0] hits_tens,
    output logic [1:0] big_left,
    output logic       repeat_shot,
    output logic       reject,
    output logic       game_over
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_HOLD, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [3:0]             r_shot_x, r_shot_y;
    logic                   r_shot_big;
    logic                   r_hit, r_near, r_miss, r_repeat, r_reject, r_game_over;
    logic [4:0]             r_ships;
    logic [3:0]             r_ones, r_tens;
    logic [1:0]             r_big_left;
    logic [99:0]            r_map;

    logic       w_sync, w_press, w_in_range, w_repeat, w_count;
    logic       w_accept, w_reject;
    logic [6:0] w_row, w_col, w_idx, w_hits_bin;
    logic [3:0] w_ones_n, w_tens_n;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_press = ~w_sync & r_prev;

    assign w_in_range = (r_shot_x >= 4'd1) && (r_shot_x <= 4'd10) &&
                        (r_shot_y >= 4'd1) && (r_shot_y <= 4'd10);
    assign w_row      = {3'b000, r_shot_y} - 7'd1;
    assign w_col      = {3'b000, r_shot_x} - 7'd1;
    assign w_idx      = w_row * 7'd10 + w_col;
    assign w_repeat   = ~r_shot_big & w_in_range & r_map[w_idx];
    assign w_count    = (r_state == S_EVAL) & ~w_repeat & is_hit;

    // BCD increment saturating at 99
    always_comb begin
        w_ones_n = r_ones;
        w_tens_n = r_tens;
        if (w_count && !(r_tens == 4'd9 && r_ones == 4'd9)) begin
            if (r_ones == 4'd9) begin
                w_ones_n = 4'd0;
                w_tens_n = r_tens + 4'd1;
            end else begin
                w_ones_n = r_ones + 4'd1;
            end
        end
    end

    assign w_hits_bin = {3'b000, w_tens_n} * 7'd10 + {3'b000, w_ones_n};

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press && !r_game_over) begin
                    if (something_wrong || (sw_big && r_big_left == 2'd0)) begin
                        w_reject = 1'b1;
                        w_next   = S_HOLD;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_EVAL;
                    end
                end
            end
            S_EVAL:  w_next = (w_hits_bin == 7'(TOTAL_SHIP_SQUARES)) ? S_DONE : S_HOLD;
            S_HOLD:  if (w_sync) w_next = S_IDLE;
            default: w_next = S_DONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Key synchroniser presets to "released" so reset never produces a press
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], score_n};
            r_prev <= w_sync;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shot_x    <= '0;
            r_shot_y    <= '0;
            r_shot_big  <= 1'b0;
            r_hit       <= 1'b0;
            r_near      <= 1'b0;
            r_miss      <= 1'b0;
            r_repeat    <= 1'b0;
            r_reject    <= 1'b0;
            r_game_over <= 1'b0;
            r_ships     <= '0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_big_left  <= 2'(BIG_BOMBS);
            r_map       <= '0;
        end else begin
            if (w_accept) begin
                r_shot_x   <= sw_x;
                r_shot_y   <= sw_y;
                r_shot_big <= sw_big;
                r_reject   <= 1'b0;
            end
            if (w_reject) begin
                r_reject <= 1'b1;
                r_hit    <= 1'b0;
                r_near   <= 1'b0;
                r_miss   <= 1'b0;
                r_repeat <= 1'b0;
            end
            if (r_state == S_EVAL) begin
                if (w_repeat) begin
                    r_repeat <= 1'b1;
                    r_hit    <= 1'b0;
                    r_near   <= 1'b0;
                    r_miss   <= 1'b0;
                end else begin
                    r_repeat <= 1'b0;
                    r_hit    <= is_hit;
                    r_near   <= is_near_miss;
                    r_miss   <= is_miss;
                    r_ones   <= w_ones_n;
                    r_tens   <= w_tens_n;
                    if (w_in_range) r_map[w_idx] <= 1'b1;
                    if (is_hit) r_ships <= r_ships | biggest_ship;
                    if (r_shot_big && r_big_left != 2'd0) r_big_left <= r_big_left - 2'd1;
                end
                if (w_next == S_DONE) r_game_over <= 1'b1;
            end
        end
    end

    assign shot_x        = r_shot_x;
    assign shot_y        = r_shot_y;
    assign shot_big      = r_shot_big;
    assign score_strobe  = (r_state == S_EVAL);
    assign hit_led       = r_hit;
    assign near_miss_led = r_near;
    assign miss_led      = r_miss;
    assign ship_hit_leds = r_ships;
    assign hits_ones     = r_ones;
    assign hits_tens     = r_tens;
    assign big_left      = r_big_left;
    assign repeat_shot   = r_repeat;
    assign reject        = r_reject;
    assign game_over     = r_game_over;

endmodule

// File: tb/tb_shot_tracker.sv
// Table-driven scoreboard bench for shot_tracker, plus hand-written sequences
// for the game-over and reset-during-evaluation corners.
module tb_shot_tracker;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned BIGB  = 2;
    localparam int unsigned TOTAL = 19;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       score_n = 1'b1;
    logic [3:0] sw_x = '0, sw_y = '0;
    logic       sw_big = 1'b0, something_wrong = 1'b0;
    logic       is_hit = 1'b0, is_near_miss = 1'b0, is_miss = 1'b0;
    logic [4:0] biggest_ship = '0;
    logic [3:0] shot_x, shot_y, hits_ones, hits_tens;
    logic       shot_big, score_strobe, hit_led, near_miss_led, miss_led;
    logic       repeat_shot, reject, game_over;
    logic [4:0] ship_hit_leds;
    logic [1:0] big_left;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    shot_tracker #(
        .SYNC_STAGES(SYNC),
        .BIG_BOMBS(BIGB),
        .TOTAL_SHIP_SQUARES(TOTAL)
    ) dut (
        .clock(clock), .reset(reset), .score_n(score_n),
        .sw_x(sw_x), .sw_y(sw_y), .sw_big(sw_big), .something_wrong(something_wrong),
        .is_hit(is_hit), .is_near_miss(is_near_miss), .is_miss(is_miss),
        .biggest_ship(biggest_ship),
        .shot_x(shot_x), .shot_y(shot_y), .shot_big(shot_big), .score_strobe(score_strobe),
        .hit_led(hit_led), .near_miss_led(near_miss_led), .miss_led(miss_led),
        .ship_hit_leds(ship_hit_leds), .hits_ones(hits_ones), .hits_tens(hits_tens),
        .big_left(big_left), .repeat_shot(repeat_shot), .reject(reject), .game_over(game_over)
    );

    typedef struct packed {
        logic [3:0] x, y;
        logic       big, wrong, hit, near, miss;
        logic [4:0] ship;
        logic [7:0] hold;
        logic       e_strobe, e_hit, e_near, e_miss, e_rep, e_rej, e_go;
        logic [3:0] e_ones, e_tens;
        logic [1:0] e_bl;
        logic [4:0] e_ships;
    } vec_t;

    vec_t sb[$];

    function automatic vec_t mk(
        input logic [3:0] x, y, input logic big, wrong, hit, near, miss,
        input logic [4:0] ship, input logic [7:0] hold,
        input logic e_strobe, e_hit, e_near, e_miss, e_rep, e_rej, e_go,
        input logic [3:0] e_ones, e_tens, input logic [1:0] e_bl, input logic [4:0] e_ships);
        vec_t v;
        v.x = x; v.y = y; v.big = big; v.wrong = wrong;
        v.hit = hit; v.near = near; v.miss = miss; v.ship = ship; v.hold = hold;
        v.e_strobe = e_strobe; v.e_hit = e_hit; v.e_near = e_near; v.e_miss = e_miss;
        v.e_rep = e_rep; v.e_rej = e_rej; v.e_go = e_go;
        v.e_ones = e_ones; v.e_tens = e_tens; v.e_bl = e_bl; v.e_ships = e_ships;
        return v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state;
        check("rst_strobe", score_strobe, 0);
        check("rst_leds", {hit_led, near_miss_led, miss_led, repeat_shot, reject, game_over}, 0);
        check("rst_hits", {hits_tens, hits_ones}, 0);
        check("rst_ships", ship_hit_leds, 0);
        check("rst_big_left", big_left, BIGB);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   nstrobe;
        int   lat;
        sw_x = v.x; sw_y = v.y; sw_big = v.big; something_wrong = v.wrong;
        is_hit = v.hit; is_near_miss = v.near; is_miss = v.miss; biggest_ship = v.ship;
        sb.push_back(v);
        score_n = 1'b0;
        nstrobe = 0;
        lat = 0;
        for (int c = 1; c <= int'(v.hold); c++) begin
            tick();
            if (lat != 0 && c == lat + 1) begin
                check("t2_hit_led", hit_led, v.e_hit);
                check("t2_repeat", repeat_shot, v.e_rep);
            end
            if (score_strobe) begin
                nstrobe++;
                if (nstrobe == 1) begin
                    lat = c;
                    check("strobe_latency", lat, SYNC + 1);
                    check("shot_xy", {shot_x, shot_y, shot_big}, {v.x, v.y, v.big});
                    // switches move once latched; the in-flight shot must not notice
                    sw_x = 4'd15; sw_y = 4'd15; sw_big = ~v.big;
                end
            end
        end
        score_n = 1'b1;
        repeat (SYNC + 3) tick();
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("strobe_count", nstrobe, e.e_strobe);
            if (e.e_strobe) check("shot_held", {shot_x, shot_y, shot_big}, {e.x, e.y, e.big});
            check("result_leds", {hit_led, near_miss_led, miss_led}, {e.e_hit, e.e_near, e.e_miss});
            check("repeat_shot", repeat_shot, e.e_rep);
            check("reject", reject, e.e_rej);
            check("game_over", game_over, e.e_go);
            check("hits_bcd", {hits_tens, hits_ones}, {e.e_tens, e.e_ones});
            check("big_left", big_left, e.e_bl);
            check("ship_hit_leds", ship_hit_leds, e.e_ships);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        score_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vec_t tbl[9];
        int   n;
        int   x, y;
        logic got;

        //            x      y     bg wr h  n  m  ship      hold st h  n  m  rp rj go ones  tens  bl    ships
        tbl[0] = mk(4'd7,  4'd6,  0, 0, 1, 0, 0, 5'b00001, 50, 1, 1, 0, 0, 0, 0, 0, 4'd1, 4'd0, 2'd2, 5'b00001);
        tbl[1] = mk(4'd7,  4'd6,  0, 0, 1, 0, 0, 5'b00001, 10, 1, 0, 0, 0, 1, 0, 0, 4'd1, 4'd0, 2'd2, 5'b00001);
        tbl[2] = mk(4'd1,  4'd1,  0, 0, 0, 0, 1, 5'b00000, 10, 1, 0, 0, 1, 0, 0, 0, 4'd1, 4'd0, 2'd2, 5'b00001);
        tbl[3] = mk(4'd10, 4'd10, 1, 0, 0, 1, 0, 5'b00000, 10, 1, 0, 1, 0, 0, 0, 0, 4'd1, 4'd0, 2'd1, 5'b00001);
        tbl[4] = mk(4'd2,  4'd2,  0, 1, 1, 0, 0, 5'b00010, 10, 0, 0, 0, 0, 0, 1, 0, 4'd1, 4'd0, 2'd1, 5'b00001);
        tbl[5] = mk(4'd1,  4'd1,  1, 0, 1, 0, 0, 5'b00100, 10, 1, 1, 0, 0, 0, 0, 0, 4'd2, 4'd0, 2'd0, 5'b00101);
        tbl[6] = mk(4'd4,  4'd4,  1, 0, 1, 0, 0, 5'b01000, 10, 0, 0, 0, 0, 0, 1, 0, 4'd2, 4'd0, 2'd0, 5'b00101);
        tbl[7] = mk(4'd10, 4'd10, 0, 0, 1, 0, 0, 5'b10000, 10, 1, 0, 0, 0, 1, 0, 0, 4'd2, 4'd0, 2'd0, 5'b00101);
        tbl[8] = mk(4'd1,  4'd1,  0, 0, 0, 0, 1, 5'b00000, 10, 1, 0, 0, 0, 1, 0, 0, 4'd2, 4'd0, 2'd0, 5'b00101);

        do_reset();
        check_reset_state();

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // Fill to the game-ending hit count on fresh squares
        n = 2;
        for (int k = 0; k < 17; k++) begin
            n++;
            x = (k < 10) ? k + 1 : k - 9;
            y = (k < 10) ? 8 : 9;
            run_vec(mk(4'(x), 4'(y), 0, 0, 1, 0, 0, 5'b00010, 10, 1, 1, 0, 0, 0, 0,
                       (n == int'(TOTAL)), 4'(n % 10), 4'(n / 10), 2'd0, 5'b00111));
        end

        run_vec(mk(4'd2, 4'd3, 0, 0, 1, 0, 0, 5'b00001, 10, 0, 1, 0, 0, 0, 0, 1,
                   4'd9, 4'd1, 2'd0, 5'b00111));

        do_reset();
        check_reset_state();
        run_vec(mk(4'd7, 4'd6, 1, 0, 1, 0, 0, 5'b01000, 10, 1, 1, 0, 0, 0, 0, 0,
                   4'd1, 4'd0, 2'd1, 5'b01000));

        // Reset lands on the evaluation cycle of a hit
        sw_x = 4'd5; sw_y = 4'd5; sw_big = 1'b0; something_wrong = 1'b0;
        is_hit = 1'b1; is_near_miss = 1'b0; is_miss = 1'b0; biggest_ship = 5'b00100;
        score_n = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (score_strobe) got = 1'b1;
        end
        check("eval_reached", got, 1);
        reset = 1'b1;
        score_n = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state();
        repeat (SYNC + 3) tick();
        check_reset_state();

        run_vec(mk(4'd7, 4'd6, 0, 0, 1, 0, 0, 5'b10000, 10, 1, 1, 0, 0, 0, 0, 0,
                   4'd1, 4'd0, 2'd2, 5'b10000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
